// File: rtl/mad_min_select_pkg.sv
// Shared widths, default serial-register length and FSM state encoding for mad_min_select.
// No logic here; constants and types only.
// Imported by the top level and the best-value register.
package mad_min_select_pkg;

    localparam int MAD_W         = 12;
    localparam int COORD_W       = 8;
    localparam int DEF_SHIFT_LEN = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/mad_min_select_if.sv
// Candidate stream in, best-result / load-pulse out, bundled for mad_min_select.
// Pure wiring, zero latency.
// mad_ready advertises when candidates are consumed; there is no other backpressure.
interface mad_min_select_if;

    logic                                    start;
    logic                                    mad_valid;
    logic [mad_min_select_pkg::MAD_W-1:0]    mad_in;
    logic [mad_min_select_pkg::COORD_W-1:0]  coord_in;
    logic                                    last;
    logic                                    mad_ready;
    logic [mad_min_select_pkg::COORD_W-1:0]  coordinate;
    logic [mad_min_select_pkg::MAD_W-1:0]    mad;
    logic                                    en_input;
    logic                                    busy;

    modport slave (
        input  start, mad_valid, mad_in, coord_in, last,
        output mad_ready, coordinate, mad, en_input, busy
    );

    modport master (
        output start, mad_valid, mad_in, coord_in, last,
        input  mad_ready, coordinate, mad, en_input, busy
    );

endinterface

// File: rtl/mad_best_reg.sv
// Running minimum of (MAD, coordinate) over accepted candidates; earliest wins ties.
// nxt_* is combinational (current best folded with this cycle's candidate); registers update each edge.
// No backpressure: every cycle with accept=1 consumes one candidate.
module mad_best_reg
    import mad_min_select_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               accept,
    input  logic               first,
    input  logic [MAD_W-1:0]   mad_in,
    input  logic [COORD_W-1:0] coord_in,
    output logic [MAD_W-1:0]   nxt_mad,
    output logic [COORD_W-1:0] nxt_coord
);

    logic [MAD_W-1:0]   best_mad;
    logic [COORD_W-1:0] best_coord;

    // First candidate loads unconditionally (so 0xFFF is kept); later ones only on strictly smaller MAD.
    always_comb begin
        nxt_mad   = best_mad;
        nxt_coord = best_coord;
        if (accept && (first || (mad_in < best_mad))) begin
            nxt_mad   = mad_in;
            nxt_coord = coord_in;
        end
    end

    // Best-value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_mad   <= '0;
            best_coord <= '0;
        end else begin
            best_mad   <= nxt_mad;
            best_coord <= nxt_coord;
        end
    end

endmodule

// File: rtl/mad_min_select.sv
// Block-search minimum selector: picks the lowest-MAD motion vector and loads it into a serial output register.
// en_input pulses one cycle after the last candidate is accepted; coordinate/mad hold until the next pulse.
// Candidates are taken only while mad_ready=1; DRAIN holds off the next search until the shift-out completes.
module mad_min_select
    import mad_min_select_pkg::*;
#(
    parameter int SHIFT_LEN = DEF_SHIFT_LEN
) (
    input  logic            clk,
    input  logic            rst,
    mad_min_select_if.slave bus
);

    localparam int                CNT_W    = $clog2(SHIFT_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SHIFT_LEN - 2);

    state_t             state;
    logic               first;
    logic [CNT_W-1:0]   drain_cnt;
    logic               mad_ready;
    logic               busy;
    logic               en_input;
    logic [COORD_W-1:0] coordinate;
    logic [MAD_W-1:0]   mad;

    logic               accept;
    logic [MAD_W-1:0]   nxt_mad;
    logic [COORD_W-1:0] nxt_coord;

    // Candidates count only in SEARCH; valid elsewhere is dropped.
    assign accept = (state == ST_SEARCH) && bus.mad_valid;

    mad_best_reg u_best (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .first     (first),
        .mad_in    (bus.mad_in),
        .coord_in  (bus.coord_in),
        .nxt_mad   (nxt_mad),
        .nxt_coord (nxt_coord)
    );

    // Search FSM with registered outputs; DRAIN spaces successive loads by the shift-register length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            first      <= 1'b0;
            drain_cnt  <= '0;
            mad_ready  <= 1'b0;
            busy       <= 1'b0;
            en_input   <= 1'b0;
            coordinate <= '0;
            mad        <= '0;
        end else begin
            en_input <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_SEARCH;
                        first     <= 1'b1;
                        mad_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (bus.mad_valid) begin
                        first <= 1'b0;
                        if (bus.last) begin
                            // Capture the best including this final candidate, so EMIT drives it directly.
                            state      <= ST_EMIT;
                            mad_ready  <= 1'b0;
                            en_input   <= 1'b1;
                            coordinate <= nxt_coord;
                            mad        <= nxt_mad;
                        end
                    end
                end
                ST_EMIT: begin
                    state     <= ST_DRAIN;
                    drain_cnt <= '0;
                end
                ST_DRAIN: begin
                    if (drain_cnt == CNT_LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    mad_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mad_ready  = mad_ready;
    assign bus.busy       = busy;
    assign bus.en_input   = en_input;
    assign bus.coordinate = coordinate;
    assign bus.mad        = mad;

endmodule

// File: doc/mad_min_select.md
MAD_MIN_SELECT -- requirements
Module: mad_min_select

Interface
REQ-001 The block SHALL have parameter SHIFT_LEN, default 20, giving the serial output register length (coordinate 8 + MAD 12) in cycles.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, which begins a new block search.
REQ-005 The block SHALL have port mad_valid, input, 1, which qualifies mad_in, coord_in and last.
REQ-006 The block SHALL have port mad_in, input, 12, the candidate MAD value.
REQ-007 The block SHALL have port coord_in, input, 8, the candidate motion vector {x[3:0], y[3:0]}.
REQ-008 The block SHALL have port last, input, 1, which marks the final candidate of the search.
REQ-009 The block SHALL have port mad_ready, output, 1, high while candidates are accepted.
REQ-010 The block SHALL have port coordinate, output, 8, the best motion vector, fed to the serial output register.
REQ-011 The block SHALL have port mad, output, 12, the best MAD, fed to the serial output register.
REQ-012 The block SHALL have port en_input, output, 1, a one-cycle load pulse for the serial output register.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, SEARCH, EMIT and DRAIN.
REQ-015 IDLE: start=1 SHALL move the FSM to SEARCH and set the first-candidate flag; mad_valid in IDLE SHALL be ignored, including when it coincides with start.
REQ-016 SEARCH: mad_ready SHALL be 1, and each cycle with mad_valid=1 accepts one candidate.
REQ-017 The first accepted candidate SHALL load best_mad and best_coord unconditionally, so that mad_in=0xFFF is still recorded.
REQ-018 Each later candidate SHALL replace the best only if mad_in < best_mad, using an unsigned 12-bit compare; on a tie the earliest candidate SHALL be kept.
REQ-019 When mad_valid=1 and last=1, the block SHALL include that candidate in the compare and go to EMIT; last without mad_valid SHALL be ignored.
REQ-020 EMIT SHALL last one cycle, with en_input=1 and coordinate/mad driven from registers holding the final best; en_input SHALL therefore assert exactly 1 cycle after the last candidate is accepted.
REQ-021 DRAIN SHALL count SHIFT_LEN-1 cycles and then go to IDLE, so that the next EMIT cannot occur until at least SHIFT_LEN+1 cycles after the previous one, leaving the serial shift-out uncorrupted.
REQ-022 coordinate and mad SHALL hold stable from EMIT until the next EMIT.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 mad_valid SHALL be ignored outside SEARCH.
REQ-025 en_input SHALL be 0 in every state except EMIT.
REQ-026 The DRAIN counter SHALL be $clog2(SHIFT_LEN) bits wide and SHALL not wrap past its terminal count.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state to IDLE, coordinate to 0, mad to 0, en_input to 0, mad_ready to 0, busy to 0, best registers to 0, the DRAIN counter to 0 and the first-candidate flag to 0.
REQ-028 rst asserted mid-SEARCH or mid-DRAIN SHALL abandon the search with no en_input pulse; after release the block SHALL wait in IDLE for start.

Structure
REQ-029 The shared package SHALL hold MAD_W=12, COORD_W=8, the default SHIFT_LEN=20, and the state enum used by the FSM.
REQ-030 The block SHALL use one sub-module, mad_best_reg, which holds the compare-and-update logic and the best-value registers; the FSM and DRAIN counter SHALL stay in the top level.

Verification
REQ-031 Scenario (basic minimum): start; candidates (coord, mad) = (0x00,0x100), (0x11,0x050), (0x22,0x080, last) -> one en_input pulse 1 cycle after the last candidate, with coordinate=0x11 and mad=0x050.
REQ-032 Scenario (tie and saturated MAD): start; candidates (0x00,0xFFF), (0x01,0xFFF, last) -> coordinate=0x00, mad=0xFFF.
REQ-033 Scenario (DRAIN spacing): run two back-to-back searches, each with a single last candidate, with start held high throughout -> the two en_input pulses are 22 cycles apart (pulse, 19 DRAIN cycles, IDLE, SEARCH, pulse), and start is ignored while busy.
REQ-034 Scenario (ignored inputs): mad_valid=1 with mad=0x000 while in IDLE, then in DRAIN -> neither candidate affects the best of the next search, and mad_ready=0 in both states.
REQ-035 Scenario (reset mid-search): assert rst after 3 of 5 candidates -> all outputs 0 immediately, no en_input pulse, and busy=0 until the next start.
